// File: rtl/mem_responder.sv
// Standalone data memory for the compute core: one request at a time, WAIT_STATES
// wait cycles, then a one-cycle MemReady pulse. Define MEM_FAULT_CHECK_EN to enable request fault checking.
module mem_responder #(
    parameter int WORD_SIZE   = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    MemEn,
    input  logic                    MemWrite,
    input  logic [WORD_SIZE/8-1:0]  ByteEn,
    input  logic [ADDR_WIDTH-1:0]   MemAdr,
    input  logic [WORD_SIZE-1:0]    MemWriteData,
    output logic [WORD_SIZE-1:0]    MemReadData,
    output logic                    MemReady,
    output logic                    MemFault
);

    localparam int LANES = WORD_SIZE / 8;
    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESPOND
    } state_t;

    state_t               state_reg, state_next;
    logic [3:0]           cnt_reg, cnt_next;
    logic                 latch_en;
    logic                 write_reg;
    logic [LANES-1:0]     be_reg;
    logic [IDX_W-1:0]     idx_reg;
    logic [WORD_SIZE-1:0] wdata_reg;
    logic                 fault_reg;

    logic [IDX_W-1:0]     idx_now;
    logic                 fault_now;

    assign idx_now = MemAdr[2 +: IDX_W];

`ifdef MEM_FAULT_CHECK_EN
    logic [1:0] low_lane;
    logic       be_legal;
    logic       range_bad;
    logic       align_bad;

    always_comb begin
        low_lane = 2'd0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (ByteEn[i]) begin
                low_lane = 2'(i);
            end
        end
        case (ByteEn)
            4'b0001, 4'b0010, 4'b0100, 4'b1000,
            4'b0011, 4'b1100, 4'b1111: be_legal = 1'b1;
            default:                   be_legal = 1'b0;
        endcase
        range_bad = |MemAdr[ADDR_WIDTH-1:IDX_W+2];
        // Reads only care about lane alignment when the address is not word aligned.
        if (MemWrite) begin
            align_bad = (ByteEn != '0) && (low_lane != MemAdr[1:0]);
        end else begin
            align_bad = (MemAdr[1:0] != 2'd0) && (low_lane != MemAdr[1:0]);
        end
        fault_now = range_bad | ~be_legal | align_bad;
    end
`else
    logic unused_addr_bits;

    assign unused_addr_bits = ^{MemAdr[ADDR_WIDTH-1:IDX_W+2], MemAdr[1:0]};
    assign fault_now        = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        latch_en   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (MemEn) begin
                    latch_en   = 1'b1;
                    cnt_next   = WAIT_LOAD;
                    state_next = (WAIT_STATES > 0) ? WAIT : RESPOND;
                end
            end
            WAIT: begin
                cnt_next = cnt_reg - 4'd1;
                if (cnt_reg <= 4'd1) begin
                    state_next = RESPOND;
                end
            end
            RESPOND: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            cnt_reg   <= 4'd0;
            write_reg <= 1'b0;
            be_reg    <= '0;
            idx_reg   <= '0;
            wdata_reg <= '0;
            fault_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (latch_en) begin
                write_reg <= MemWrite;
                be_reg    <= ByteEn;
                idx_reg   <= idx_now;
                wdata_reg <= MemWriteData;
                fault_reg <= fault_now;
            end
        end
    end

    // With zero wait states RESPOND is entered straight from IDLE, so the
    // request has to come from the live inputs rather than the latched copy.
    logic             in_idle;
    logic             req_write;
    logic             req_fault;
    logic [IDX_W-1:0] req_idx;
    logic             load_read;
    logic             load_zero;
    logic             mem_we;

    assign in_idle   = (state_reg == IDLE);
    assign req_write = in_idle ? MemWrite  : write_reg;
    assign req_fault = in_idle ? fault_now : fault_reg;
    assign req_idx   = in_idle ? idx_now   : idx_reg;
    assign load_read = (state_next == RESPOND) && !req_write && !req_fault;
    assign load_zero = (state_next == RESPOND) && req_fault;
    assign mem_we    = (state_reg == RESPOND) && write_reg && !fault_reg;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH_WORDS];
            logic [7:0] rd_byte_reg;

            always_ff @(posedge clk) begin
                if (mem_we && be_reg[gi]) begin
                    lane_mem[idx_reg] <= wdata_reg[8*gi +: 8];
                end
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    rd_byte_reg <= 8'd0;
                end else if (load_zero) begin
                    rd_byte_reg <= 8'd0;
                end else if (load_read) begin
                    rd_byte_reg <= lane_mem[req_idx];
                end
            end

            assign MemReadData[8*gi +: 8] = rd_byte_reg;
        end
    endgenerate

    assign MemReady = (state_reg == RESPOND);
    assign MemFault = (state_reg == RESPOND) && fault_reg;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: a WAIT_STATES=2 unit (index 0) and a WAIT_STATES=0 unit (index 1)
// checked against a word-array reference model built from the addressing and byte-lane rules.
module tb_mem_responder;

    localparam int DEPTH = 1024;
    localparam int LAT0  = 3;   // WAIT_STATES=2 -> ready in 3rd cycle after sampling edge
    localparam int LAT1  = 1;   // WAIT_STATES=0

    logic        clk;
    logic        reset;
    logic        mem_en    [2];
    logic        mem_write [2];
    logic [3:0]  byte_en   [2];
    logic [31:0] mem_adr   [2];
    logic [31:0] mem_wdata [2];
    logic [31:0] mem_rdata [2];
    logic        mem_ready [2];
    logic        mem_fault [2];

    int n_tests = 0;
    int n_fail  = 0;

    bit [31:0] ref_word [2][DEPTH];

    mem_responder #(.WORD_SIZE(32), .ADDR_WIDTH(32), .DEPTH_WORDS(DEPTH), .WAIT_STATES(2)) u_dut_ws2 (
        .clk(clk), .reset(reset), .MemEn(mem_en[0]), .MemWrite(mem_write[0]), .ByteEn(byte_en[0]),
        .MemAdr(mem_adr[0]), .MemWriteData(mem_wdata[0]), .MemReadData(mem_rdata[0]),
        .MemReady(mem_ready[0]), .MemFault(mem_fault[0])
    );

    mem_responder #(.WORD_SIZE(32), .ADDR_WIDTH(32), .DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) u_dut_ws0 (
        .clk(clk), .reset(reset), .MemEn(mem_en[1]), .MemWrite(mem_write[1]), .ByteEn(byte_en[1]),
        .MemAdr(mem_adr[1]), .MemWriteData(mem_wdata[1]), .MemReadData(mem_rdata[1]),
        .MemReady(mem_ready[1]), .MemFault(mem_fault[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic bit ref_fault(input bit w, input bit [3:0] be, input bit [31:0] adr);
`ifdef MEM_FAULT_CHECK_EN
        int low = 0;
        for (int i = 3; i >= 0; i--) if (be[i]) low = i;
        if (adr >= 4 * DEPTH) return 1'b1;
        if (!(be inside {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111})) return 1'b1;
        if (w && be != 0 && low != int'(adr % 4)) return 1'b1;
        if (!w && (adr % 4) != 0 && low != int'(adr % 4)) return 1'b1;
        return 1'b0;
`else
        return (w & 1'b0) | (be[0] & 1'b0) | (adr[0] & 1'b0);
`endif
    endfunction

    function automatic bit [31:0] ref_read(input int u, input bit [31:0] adr);
        if (ref_fault(1'b0, 4'hF, adr)) return 32'd0;
        return ref_word[u][(adr / 4) % DEPTH];
    endfunction

    task automatic ref_write(input int u, input bit [3:0] be, input bit [31:0] adr, input bit [31:0] wd);
        int idx = int'((adr / 4) % DEPTH);
        if (ref_fault(1'b1, be, adr)) return;
        for (int i = 0; i < 4; i++)
            if (be[i]) ref_word[u][idx][8*i +: 8] = wd[8*i +: 8];
    endtask

    // ---------------- driver (no checking) ----------------
    task automatic do_req(input int u, input bit w, input bit [3:0] be, input bit [31:0] adr,
                          input bit [31:0] wd, output int lat, output bit [31:0] rd, output bit flt);
        @(negedge clk);
        mem_en[u] = 1'b1; mem_write[u] = w; byte_en[u] = be; mem_adr[u] = adr; mem_wdata[u] = wd;
        @(posedge clk);
        #1 mem_en[u] = 1'b0;
        lat = -1; rd = 32'd0; flt = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (mem_ready[u] === 1'b1) begin
                lat = c; rd = mem_rdata[u]; flt = mem_fault[u];
                break;
            end
        end
        if (lat > 0) @(posedge clk);
        $display("[TB] u%0d %s adr=%h be=%b wd=%h -> lat=%0d rd=%h fault=%0b",
                 u, w ? "WR" : "RD", adr, be, wd, lat, rd, flt);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #2 reset = 1'b1;
        #1;
        for (int u = 0; u < 2; u++) begin
            n_tests++; if (mem_ready[u] !== 1'b0) begin n_fail++; $display("FAIL reset_ready u%0d got=%b exp=0", u, mem_ready[u]); end
            n_tests++; if (mem_fault[u] !== 1'b0) begin n_fail++; $display("FAIL reset_fault u%0d got=%b exp=0", u, mem_fault[u]); end
            n_tests++; if (mem_rdata[u] !== 32'd0) begin n_fail++; $display("FAIL reset_rdata u%0d got=%h exp=0", u, mem_rdata[u]); end
        end
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            for (int u = 0; u < 2; u++) begin
                n_tests++;
                if ({mem_ready[u], mem_fault[u], mem_rdata[u]} !== 34'd0) begin
                    n_fail++; $display("FAIL idle_outputs u%0d cyc%0d got=%b/%b/%h exp=0/0/0", u, c, mem_ready[u], mem_fault[u], mem_rdata[u]);
                end
            end
        end
    endtask

    task automatic test_word_rw();
        int lat; bit [31:0] rd; bit flt;
        do_req(0, 1'b1, 4'hF, 32'h40, 32'hDEADBEEF, lat, rd, flt);
        ref_write(0, 4'hF, 32'h40, 32'hDEADBEEF);
        n_tests++; if (lat !== LAT0) begin n_fail++; $display("FAIL wr_latency got=%0d exp=%0d", lat, LAT0); end
        n_tests++; if (flt !== 1'b0) begin n_fail++; $display("FAIL wr_fault got=%b exp=0", flt); end
        do_req(0, 1'b0, 4'hF, 32'h40, 32'h0, lat, rd, flt);
        n_tests++; if (lat !== LAT0) begin n_fail++; $display("FAIL rd_latency got=%0d exp=%0d", lat, LAT0); end
        n_tests++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_word got=%h exp=%h", rd, 32'hDEADBEEF); end
    endtask

    task automatic test_byte_merge();
        int lat; bit [31:0] rd; bit flt;
        do_req(0, 1'b1, 4'b0010, 32'h41, 32'h0000AA00, lat, rd, flt);
        ref_write(0, 4'b0010, 32'h41, 32'h0000AA00);
        n_tests++; if (flt !== 1'b0) begin n_fail++; $display("FAIL merge_wr_fault got=%b exp=0", flt); end
        do_req(0, 1'b0, 4'hF, 32'h40, 32'h0, lat, rd, flt);
        n_tests++; if (rd !== 32'hDEADAAEF) begin n_fail++; $display("FAIL merge_rd got=%h exp=%h", rd, 32'hDEADAAEF); end
    endtask

    task automatic test_zero_wait();
        int lat; bit [31:0] rd; bit flt; bit [31:0] wd; int k;
        bit [31:0] adrs [3];
        for (int i = 0; i < 3; i++) begin
            adrs[i] = 32'h200 + 32'(4 * i);
            wd = $urandom;
            do_req(1, 1'b1, 4'hF, adrs[i], wd, lat, rd, flt);
            ref_write(1, 4'hF, adrs[i], wd);
            n_tests++; if (lat !== LAT1) begin n_fail++; $display("FAIL zw_wr_latency got=%0d exp=%0d", lat, LAT1); end
        end
        @(negedge clk);
        mem_en[1] = 1'b1; mem_write[1] = 1'b0; byte_en[1] = 4'hF; mem_adr[1] = adrs[0];
        k = 0;
        for (int n = 1; n <= 6; n++) begin
            @(negedge clk);
            n_tests++;
            if (mem_ready[1] !== ((n % 2) == 1)) begin n_fail++; $display("FAIL zw_ready cyc%0d got=%b exp=%b", n, mem_ready[1], (n % 2) == 1); end
            if (mem_ready[1] === 1'b1 && k < 3) begin
                n_tests++;
                if (mem_rdata[1] !== ref_read(1, adrs[k])) begin n_fail++; $display("FAIL zw_rdata k%0d got=%h exp=%h", k, mem_rdata[1], ref_read(1, adrs[k])); end
                $display("[TB] u1 RD stream adr=%h rd=%h", adrs[k], mem_rdata[1]);
                k++;
                if (k < 3) mem_adr[1] = adrs[k]; else mem_en[1] = 1'b0;
            end
        end
        mem_en[1] = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        bit [31:0] adrs [3]; int k;
        adrs[0] = 32'h40; adrs[1] = 32'h40; adrs[2] = 32'h40;
        @(negedge clk);
        mem_en[0] = 1'b1; mem_write[0] = 1'b0; byte_en[0] = 4'hF; mem_adr[0] = adrs[0];
        k = 0;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            n_tests++;
            if (mem_ready[0] !== ((n % 4) == 3)) begin n_fail++; $display("FAIL b2b_ready cyc%0d got=%b exp=%b", n, mem_ready[0], (n % 4) == 3); end
            if (mem_ready[0] === 1'b1 && k < 3) begin
                n_tests++;
                if (mem_rdata[0] !== ref_read(0, adrs[k])) begin n_fail++; $display("FAIL b2b_rdata k%0d got=%h exp=%h", k, mem_rdata[0], ref_read(0, adrs[k])); end
                $display("[TB] u0 RD stream adr=%h rd=%h", adrs[k], mem_rdata[0]);
                k++;
                if (k == 3) mem_en[0] = 1'b0;
            end
        end
        mem_en[0] = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic test_reset_mid_write();
        int lat; bit [31:0] rd; bit flt;
        do_req(0, 1'b1, 4'hF, 32'h80, 32'hCAFEF00D, lat, rd, flt);
        ref_write(0, 4'hF, 32'h80, 32'hCAFEF00D);
        do_req(0, 1'b0, 4'hF, 32'h80, 32'h0, lat, rd, flt);
        n_tests++; if (rd !== 32'hCAFEF00D) begin n_fail++; $display("FAIL seed_rd got=%h exp=%h", rd, 32'hCAFEF00D); end
        @(negedge clk);
        mem_en[0] = 1'b1; mem_write[0] = 1'b1; byte_en[0] = 4'hF; mem_adr[0] = 32'h80; mem_wdata[0] = 32'h12345678;
        @(posedge clk);
        #1 mem_en[0] = 1'b0;
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        n_tests++; if (mem_rdata[0] !== 32'd0) begin n_fail++; $display("FAIL midrst_rdata got=%h exp=0", mem_rdata[0]); end
        n_tests++; if (mem_ready[0] !== 1'b0) begin n_fail++; $display("FAIL midrst_ready got=%b exp=0", mem_ready[0]); end
        @(posedge clk);
        @(negedge clk) reset = 1'b0;
        $display("[TB] u0 WR adr=00000080 aborted by reset");
        do_req(0, 1'b0, 4'hF, 32'h80, 32'h0, lat, rd, flt);
        n_tests++; if (lat !== LAT0) begin n_fail++; $display("FAIL midrst_lat got=%0d exp=%0d", lat, LAT0); end
        n_tests++; if (rd !== ref_read(0, 32'h80)) begin n_fail++; $display("FAIL midrst_word got=%h exp=%h", rd, ref_read(0, 32'h80)); end
    endtask

    task automatic test_fault();
        int lat; bit [31:0] rd; bit flt;
`ifdef MEM_FAULT_CHECK_EN
        do_req(0, 1'b0, 4'hF, 32'h40, 32'h0, lat, rd, flt);
        n_tests++; if (rd !== 32'hDEADAAEF) begin n_fail++; $display("FAIL flt_pre_rd got=%h exp=%h", rd, 32'hDEADAAEF); end
        do_req(0, 1'b1, 4'hF, 32'h42, 32'h11111111, lat, rd, flt);
        ref_write(0, 4'hF, 32'h42, 32'h11111111);
        n_tests++; if (lat !== LAT0) begin n_fail++; $display("FAIL flt_wr_lat got=%0d exp=%0d", lat, LAT0); end
        n_tests++; if (flt !== 1'b1) begin n_fail++; $display("FAIL flt_wr_fault got=%b exp=1", flt); end
        n_tests++; if (rd !== 32'd0) begin n_fail++; $display("FAIL flt_wr_rdata got=%h exp=0", rd); end
        do_req(0, 1'b0, 4'hF, 32'h1000, 32'h0, lat, rd, flt);
        n_tests++; if (flt !== 1'b1) begin n_fail++; $display("FAIL flt_rd_fault got=%b exp=1", flt); end
        n_tests++; if (rd !== 32'd0) begin n_fail++; $display("FAIL flt_rd_rdata got=%h exp=0", rd); end
`else
        do_req(0, 1'b1, 4'hF, 32'h0, 32'h0BADC0DE, lat, rd, flt);
        ref_write(0, 4'hF, 32'h0, 32'h0BADC0DE);
        do_req(0, 1'b0, 4'hF, 32'h1000, 32'h0, lat, rd, flt);
        n_tests++; if (flt !== 1'b0) begin n_fail++; $display("FAIL wrap_fault got=%b exp=0", flt); end
        n_tests++; if (rd !== 32'h0BADC0DE) begin n_fail++; $display("FAIL wrap_rd got=%h exp=%h", rd, 32'h0BADC0DE); end
`endif
        do_req(0, 1'b1, 4'b0000, 32'h40, 32'hFFFFFFFF, lat, rd, flt);
        n_tests++; if (lat !== LAT0) begin n_fail++; $display("FAIL be0_lat got=%0d exp=%0d", lat, LAT0); end
        n_tests++; if (flt !== ref_fault(1'b1, 4'b0000, 32'h40)) begin n_fail++; $display("FAIL be0_fault got=%b exp=%b", flt, ref_fault(1'b1, 4'b0000, 32'h40)); end
        do_req(0, 1'b0, 4'hF, 32'h40, 32'h0, lat, rd, flt);
        n_tests++; if (rd !== 32'hDEADAAEF) begin n_fail++; $display("FAIL mem_unchanged got=%h exp=%h", rd, 32'hDEADAAEF); end
    endtask

    task automatic test_random();
        int lat; bit [31:0] rd; bit flt; bit [31:0] adr, wd; int w, sel;
        bit [3:0] pat [7] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
        int       off [7] = '{0, 1, 2, 3, 0, 2, 0};
        for (int i = 0; i < 8; i++) begin
            wd = $urandom; adr = 32'h100 + 32'(4 * i);
            do_req(0, 1'b1, 4'hF, adr, wd, lat, rd, flt);
            ref_write(0, 4'hF, adr, wd);
        end
        for (int t = 0; t < 30; t++) begin
            w = $urandom_range(0, 7);
            if ($urandom_range(0, 1) == 1) begin
                sel = $urandom_range(0, 6);
                adr = 32'h100 + 32'(4 * w + off[sel]); wd = $urandom;
                do_req(0, 1'b1, pat[sel], adr, wd, lat, rd, flt);
                ref_write(0, pat[sel], adr, wd);
                n_tests++; if (flt !== 1'b0) begin n_fail++; $display("FAIL rnd_wr_fault t%0d got=%b exp=0", t, flt); end
            end else begin
                adr = 32'h100 + 32'(4 * w);
                do_req(0, 1'b0, 4'hF, adr, 32'h0, lat, rd, flt);
                n_tests++; if (rd !== ref_read(0, adr)) begin n_fail++; $display("FAIL rnd_rd t%0d adr=%h got=%h exp=%h", t, adr, rd, ref_read(0, adr)); end
            end
            n_tests++; if (lat !== LAT0) begin n_fail++; $display("FAIL rnd_lat t%0d got=%0d exp=%0d", t, lat, LAT0); end
        end
    endtask

    initial begin
        reset = 1'b0;
        for (int u = 0; u < 2; u++) begin
            mem_en[u] = 1'b0; mem_write[u] = 1'b0; byte_en[u] = 4'h0; mem_adr[u] = 32'h0; mem_wdata[u] = 32'h0;
        end
        test_reset();
        test_word_rw();
        test_byte_merge();
        test_zero_wait();
        test_back_to_back();
        test_reset_mid_write();
        test_fault();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached after %0d tests", n_tests);
        $fatal(1, "timeout");
    end

endmodule
